// File: rtl/alu_wide_op_sequencer_if.sv
// Request/response bundle between the execute controller and the wide-op sequencer.
// The controller side takes the master modport, the sequencer the slave modport.
`ifndef ALU_WIDE_SEQ_DEFS
`define ALU_WIDE_SEQ_DEFS
`define CONST_ALU_INOUT_WIDTH     8
`define CONST_ALU_INOUT_MSB_POS   7
`define CONST_ALU_OPER_MSB_POS    3
`define CONST_PROC_FLAGS_MSB_POS  3
`define CONST_PROC_FLAG_C_POS     0
`define CONST_PROC_FLAG_Z_POS     1
`define ENUM_ALU_OPER_ADD         4'd0
`define ENUM_ALU_OPER_ADC         4'd1
`define ENUM_ALU_OPER_SUB         4'd2
`define ENUM_ALU_OPER_SBC         4'd3
`define ENUM_ALU_OPER_CMP         4'd4
`define ENUM_ALU_OPER_AND         4'd5
`define ENUM_ALU_OPER_ORR         4'd6
`define ENUM_ALU_OPER_XOR         4'd7
`define ENUM_ALU_OPER_LSL         4'd8
`define ENUM_ALU_OPER_LSR         4'd9
`define ENUM_ALU_OPER_ASR         4'd10
`define ENUM_ALU_OPER_ROL         4'd11
`define ENUM_ALU_OPER_ROR         4'd12
`endif

interface alu_wide_op_sequencer_if #(
    parameter int unsigned NUM_CHUNKS = 2,
    parameter int unsigned WIDE_WIDTH = NUM_CHUNKS * `CONST_ALU_INOUT_WIDTH
);
    logic                                 start;
    logic [`CONST_ALU_OPER_MSB_POS:0]     oper_in;
    logic [WIDE_WIDTH-1:0]                a_wide;
    logic [WIDE_WIDTH-1:0]                b_wide;
    logic [`CONST_PROC_FLAGS_MSB_POS:0]   flags_in;
    logic                                 busy;
    logic                                 done;
    logic                                 err;
    logic [WIDE_WIDTH-1:0]                result_wide;
    logic [`CONST_PROC_FLAGS_MSB_POS:0]   flags_out;

    modport master (
        output start, oper_in, a_wide, b_wide, flags_in,
        input  busy, done, err, result_wide, flags_out
    );

    modport slave (
        input  start, oper_in, a_wide, b_wide, flags_in,
        output busy, done, err, result_wide, flags_out
    );
endinterface

// File: rtl/alu_wide_op_sequencer.sv
// Runs one multi-chunk ALU request through the chunk-width alu, LS chunk first,
// chaining carry between chunks and AND-accumulating the per-chunk Z flag.
`ifndef ALU_WIDE_SEQ_DEFS
`define ALU_WIDE_SEQ_DEFS
`define CONST_ALU_INOUT_WIDTH     8
`define CONST_ALU_INOUT_MSB_POS   7
`define CONST_ALU_OPER_MSB_POS    3
`define CONST_PROC_FLAGS_MSB_POS  3
`define CONST_PROC_FLAG_C_POS     0
`define CONST_PROC_FLAG_Z_POS     1
`define ENUM_ALU_OPER_ADD         4'd0
`define ENUM_ALU_OPER_ADC         4'd1
`define ENUM_ALU_OPER_SUB         4'd2
`define ENUM_ALU_OPER_SBC         4'd3
`define ENUM_ALU_OPER_CMP         4'd4
`define ENUM_ALU_OPER_AND         4'd5
`define ENUM_ALU_OPER_ORR         4'd6
`define ENUM_ALU_OPER_XOR         4'd7
`define ENUM_ALU_OPER_LSL         4'd8
`define ENUM_ALU_OPER_LSR         4'd9
`define ENUM_ALU_OPER_ASR         4'd10
`define ENUM_ALU_OPER_ROL         4'd11
`define ENUM_ALU_OPER_ROR         4'd12
`endif

module alu_wide_op_sequencer #(
    parameter int unsigned NUM_CHUNKS = 2,
    parameter int unsigned WIDE_WIDTH = NUM_CHUNKS * `CONST_ALU_INOUT_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    alu_wide_op_sequencer_if.slave              req,
    output logic [`CONST_ALU_OPER_MSB_POS:0]    alu_oper,
    output logic [`CONST_ALU_INOUT_MSB_POS:0]   alu_a,
    output logic [`CONST_ALU_INOUT_MSB_POS:0]   alu_b,
    output logic [`CONST_PROC_FLAGS_MSB_POS:0]  alu_flags,
    input  logic [`CONST_ALU_INOUT_MSB_POS:0]   alu_out,
    input  logic [`CONST_PROC_FLAGS_MSB_POS:0]  alu_flags_res
);
    localparam int unsigned W     = `CONST_ALU_INOUT_WIDTH;
    localparam int unsigned OperW = `CONST_ALU_OPER_MSB_POS + 1;
    localparam int unsigned FlagW = `CONST_PROC_FLAGS_MSB_POS + 1;
    localparam int unsigned IdxW  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned FC    = `CONST_PROC_FLAG_C_POS;
    localparam int unsigned FZ    = `CONST_PROC_FLAG_Z_POS;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [OperW-1:0]      oper_q, oper_d;
    logic [WIDE_WIDTH-1:0] a_q, a_d;
    logic [WIDE_WIDTH-1:0] b_q, b_d;
    logic [FlagW-1:0]      flags_q, flags_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  carry_q, carry_d;
    logic                  z_acc_q, z_acc_d;
    logic [WIDE_WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDE_WIDTH-1:0] result_q, result_d;
    logic [FlagW-1:0]      flags_out_q, flags_out_d;
    logic                  err_q, err_d;

    function automatic logic is_supported(input logic [OperW-1:0] op);
        case (op)
            `ENUM_ALU_OPER_ADD, `ENUM_ALU_OPER_ADC, `ENUM_ALU_OPER_SUB, `ENUM_ALU_OPER_SBC,
            `ENUM_ALU_OPER_CMP, `ENUM_ALU_OPER_AND, `ENUM_ALU_OPER_ORR,
            `ENUM_ALU_OPER_XOR: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            oper_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            flags_q     <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            z_acc_q     <= 1'b0;
            shadow_q    <= '0;
            result_q    <= '0;
            flags_out_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            oper_q      <= oper_d;
            a_q         <= a_d;
            b_q         <= b_d;
            flags_q     <= flags_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            z_acc_q     <= z_acc_d;
            shadow_q    <= shadow_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        oper_d      = oper_q;
        a_d         = a_q;
        b_d         = b_q;
        flags_d     = flags_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        z_acc_d     = z_acc_q;
        shadow_d    = shadow_q;
        result_d    = result_q;
        flags_out_d = flags_out_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (req.start) begin
                    oper_d  = req.oper_in;
                    a_d     = req.a_wide;
                    b_d     = req.b_wide;
                    flags_d = req.flags_in;
                    if (is_supported(req.oper_in)) begin
                        state_d = StRun;
                        idx_d   = '0;
                        carry_d = req.flags_in[FC];
                        z_acc_d = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        // Unsupported: complete next cycle, result untouched, flags echoed.
                        state_d     = StDone;
                        err_d       = 1'b1;
                        flags_out_d = req.flags_in;
                    end
                end
            end
            StRun: begin
                shadow_d[idx_q*W +: W] = alu_out;
                carry_d = alu_flags_res[FC];
                z_acc_d = z_acc_q & alu_flags_res[FZ];
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    if (oper_q != `ENUM_ALU_OPER_CMP) begin
                        result_d = shadow_d;
                    end
                    flags_out_d     = flags_q;
                    flags_out_d[FC] = carry_d;
                    flags_out_d[FZ] = z_acc_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_oper  = `ENUM_ALU_OPER_ADD;
        alu_a     = '0;
        alu_b     = '0;
        alu_flags = '0;
        if (state_q == StRun) begin
            alu_a         = a_q[idx_q*W +: W];
            alu_b         = b_q[idx_q*W +: W];
            alu_flags     = flags_q;
            alu_flags[FC] = carry_q;
            case (oper_q)
                `ENUM_ALU_OPER_ADD: alu_oper = (idx_q == '0) ? `ENUM_ALU_OPER_ADD
                                                              : `ENUM_ALU_OPER_ADC;
                `ENUM_ALU_OPER_SUB,
                `ENUM_ALU_OPER_CMP: alu_oper = (idx_q == '0) ? `ENUM_ALU_OPER_SUB
                                                              : `ENUM_ALU_OPER_SBC;
                default:            alu_oper = oper_q;
            endcase
        end
    end

    assign req.busy        = (state_q == StRun);
    assign req.done        = (state_q == StDone);
    assign req.err         = err_q;
    assign req.result_wide = result_q;
    assign req.flags_out   = flags_out_q;

endmodule

// File: tb/tb_alu_wide_op_sequencer.sv
// Directed bench for alu_wide_op_sequencer with a behavioural 8-bit alu attached.
`ifndef ALU_WIDE_SEQ_DEFS
`define ALU_WIDE_SEQ_DEFS
`define CONST_ALU_INOUT_WIDTH     8
`define CONST_ALU_INOUT_MSB_POS   7
`define CONST_ALU_OPER_MSB_POS    3
`define CONST_PROC_FLAGS_MSB_POS  3
`define CONST_PROC_FLAG_C_POS     0
`define CONST_PROC_FLAG_Z_POS     1
`define ENUM_ALU_OPER_ADD         4'd0
`define ENUM_ALU_OPER_ADC         4'd1
`define ENUM_ALU_OPER_SUB         4'd2
`define ENUM_ALU_OPER_SBC         4'd3
`define ENUM_ALU_OPER_CMP         4'd4
`define ENUM_ALU_OPER_AND         4'd5
`define ENUM_ALU_OPER_ORR         4'd6
`define ENUM_ALU_OPER_XOR         4'd7
`define ENUM_ALU_OPER_LSL         4'd8
`define ENUM_ALU_OPER_LSR         4'd9
`define ENUM_ALU_OPER_ASR         4'd10
`define ENUM_ALU_OPER_ROL         4'd11
`define ENUM_ALU_OPER_ROR         4'd12
`endif

module tb_alu_wide_op_sequencer;
    localparam int unsigned NC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_wide_op_sequencer_if #(.NUM_CHUNKS(NC)) bus ();

    logic [3:0] alu_oper;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_flags, alu_flags_res;

    alu_wide_op_sequencer #(.NUM_CHUNKS(NC)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (bus),
        .alu_oper      (alu_oper),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_flags     (alu_flags),
        .alu_out       (alu_out),
        .alu_flags_res (alu_flags_res)
    );

    // Reference alu: C is carry-out (no-borrow on subtract), logic ops pass C through.
    logic [8:0] sum;
    always_comb begin
        sum = {alu_flags[0], 8'h00};
        case (alu_oper)
            `ENUM_ALU_OPER_ADD: sum = {1'b0, alu_a} + {1'b0, alu_b};
            `ENUM_ALU_OPER_ADC: sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_flags[0]};
            `ENUM_ALU_OPER_SUB: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            `ENUM_ALU_OPER_SBC: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_flags[0]};
            `ENUM_ALU_OPER_AND: sum = {alu_flags[0], alu_a & alu_b};
            `ENUM_ALU_OPER_ORR: sum = {alu_flags[0], alu_a | alu_b};
            `ENUM_ALU_OPER_XOR: sum = {alu_flags[0], alu_a ^ alu_b};
            default:            sum = {alu_flags[0], 8'h00};
        endcase
        alu_out          = sum[7:0];
        alu_flags_res    = alu_flags;
        alu_flags_res[0] = sum[8];
        alu_flags_res[1] = (sum[7:0] == 8'h00);
    end

    int total = 0;
    int passed = 0;
    int lat;
    int bcnt;
    int done_cnt = 0;
    int done_snap;
    logic [3:0] op_log [0:3];

    always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called at a negedge; start is sampled at the next posedge, then released.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f);
        bus.start    = 1'b1;
        bus.oper_in  = op;
        bus.a_wide   = a;
        bus.b_wide   = b;
        bus.flags_in = f;
        @(posedge clk);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.busy) begin
                if (bcnt < 4) op_log[bcnt] = alu_oper;
                bcnt++;
            end
            if (bus.done) break;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic chk_op(input string tag, input int exp_lat, input logic [15:0] exp_res,
                          input logic [3:0] exp_flags, input logic exp_err);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, bus.result_wide, exp_res);
        chk({tag, "_flags"}, bus.flags_out, exp_flags);
        chk({tag, "_err"}, bus.err, exp_err);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.oper_in  = '0;
        bus.a_wide   = '0;
        bus.b_wide   = '0;
        bus.flags_in = '0;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_res", bus.result_wide, 0);
        chk("rst_flags", bus.flags_out, 0);
        chk("rst_alu_oper", alu_oper, `ENUM_ALU_OPER_ADD);
        chk("rst_alu_a", alu_a, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(`ENUM_ALU_OPER_ADD, 16'h12FF, 16'h0001, 4'b0000);
        chk_op("add1", 3, 16'h1300, 4'b0000, 1'b0);
        chk("add1_busy", bcnt, 2);
        chk("add1_op0", op_log[0], `ENUM_ALU_OPER_ADD);
        chk("add1_op1", op_log[1], `ENUM_ALU_OPER_ADC);

        run_op(`ENUM_ALU_OPER_ADD, 16'hFFFF, 16'h0001, 4'b0000);
        chk_op("add2", 3, 16'h0000, 4'b0011, 1'b0);
        run_op(`ENUM_ALU_OPER_ADC, 16'h0000, 16'h0000, 4'b0001);
        chk_op("adc", 3, 16'h0001, 4'b0000, 1'b0);
        chk("adc_op0", op_log[0], `ENUM_ALU_OPER_ADC);

        run_op(`ENUM_ALU_OPER_SUB, 16'h1000, 16'h0001, 4'b0000);
        chk_op("sub1", 3, 16'h0FFF, 4'b0001, 1'b0);
        chk("sub1_op0", op_log[0], `ENUM_ALU_OPER_SUB);
        chk("sub1_op1", op_log[1], `ENUM_ALU_OPER_SBC);
        run_op(`ENUM_ALU_OPER_SUB, 16'h0000, 16'h0001, 4'b0000);
        chk_op("sub2", 3, 16'hFFFF, 4'b0000, 1'b0);
        run_op(`ENUM_ALU_OPER_SBC, 16'h0005, 16'h0003, 4'b0000);
        chk_op("sbc", 3, 16'h0001, 4'b0001, 1'b0);

        run_op(`ENUM_ALU_OPER_ADD, 16'hABCD, 16'h0000, 4'b0000);
        chk_op("prep", 3, 16'hABCD, 4'b0000, 1'b0);
        run_op(`ENUM_ALU_OPER_CMP, 16'h1234, 16'h1234, 4'b0000);
        chk_op("cmp_eq", 3, 16'hABCD, 4'b0011, 1'b0);
        run_op(`ENUM_ALU_OPER_CMP, 16'h1200, 16'h1234, 4'b0000);
        chk_op("cmp_lt", 3, 16'hABCD, 4'b0000, 1'b0);

        run_op(`ENUM_ALU_OPER_AND, 16'hF0F0, 16'h0F0F, 4'b1101);
        chk_op("and", 3, 16'h0000, 4'b1111, 1'b0);
        run_op(`ENUM_ALU_OPER_LSL, 16'h1234, 16'h0001, 4'b1010);
        chk_op("lsl", 1, 16'h0000, 4'b1010, 1'b1);
        chk("lsl_busy", bcnt, 0);
        run_op(`ENUM_ALU_OPER_ADD, 16'h0001, 16'h0001, 4'b0000);
        chk_op("err_clr", 3, 16'h0002, 4'b0000, 1'b0);

        // Start pulsed during RUN with different operands must be ignored.
        bus.start    = 1'b1;
        bus.oper_in  = `ENUM_ALU_OPER_ADD;
        bus.a_wide   = 16'h0100;
        bus.b_wide   = 16'h0100;
        bus.flags_in = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk("ign_busy", bus.busy, 1);
        bus.oper_in = `ENUM_ALU_OPER_SUB;
        bus.a_wide  = 16'hFFFF;
        bus.b_wide  = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("ign_done", bus.done, 1);
        chk("ign_res", bus.result_wide, 16'h0200);

        // Start held through DONE: a second request is accepted in the DONE cycle.
        bus.start    = 1'b1;
        bus.oper_in  = `ENUM_ALU_OPER_ADD;
        bus.a_wide   = 16'h0003;
        bus.b_wide   = 16'h0004;
        bus.flags_in = 4'b0000;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("b2b1_lat", lat, 3);
        chk("b2b1_res", bus.result_wide, 16'h0007);
        bus.oper_in = `ENUM_ALU_OPER_XOR;
        bus.a_wide  = 16'h00FF;
        bus.b_wide  = 16'h0F0F;
        @(posedge clk);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) break;
        end
        if (!bus.done) lat = -1;
        chk_op("b2b2", 3, 16'h0FF0, 4'b0000, 1'b0);
        chk("b2b2_busy", bcnt, 2);

        // Reset in the middle of RUN clears everything and never produces done.
        bus.start    = 1'b1;
        bus.oper_in  = `ENUM_ALU_OPER_ADD;
        bus.a_wide   = 16'h1111;
        bus.b_wide   = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("mid_busy", bus.busy, 1);
        done_snap = done_cnt;
        reset = 1'b1;
        #1;
        chk("mr_busy", bus.busy, 0);
        chk("mr_done", bus.done, 0);
        chk("mr_res", bus.result_wide, 0);
        chk("mr_flags", bus.flags_out, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mr_no_done", done_cnt, done_snap);
        chk("mr_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_wide_op_sequencer.md
Name: alu_wide_op_sequencer

Overview:
Initiator-side companion to the combinational `alu`. It accepts one multi-chunk arithmetic or logic request, then issues one ALU operation per clock, least-significant chunk first, chaining carry and accumulating Z. It sits between the execute controller and the `alu` instance, and gives the CPU wide add, sub and compare operations on the existing chunk-width datapath.

Parameters:
NUM_CHUNKS, 2, number of `const_alu_inout_width`-bit chunks per wide operand (at least 1).
WIDE_WIDTH, NUM_CHUNKS*`const_alu_inout_width`, derived wide operand width. Do not override.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe, sampled at posedge while busy=0
oper_in  input  `const_alu_oper_msb_pos+1  requested `enum_alu_oper_*` code
a_wide  input  WIDE_WIDTH  operand A
b_wide  input  WIDE_WIDTH  operand B
flags_in  input  `const_proc_flags_msb_pos+1  processor flags at request time
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse
err  output  1  valid with done; unsupported oper
result_wide  output  WIDE_WIDTH  wide result, held until next completion
flags_out  output  `const_proc_flags_msb_pos+1  flags result, held until next completion
alu_oper  output  `const_alu_oper_msb_pos+1  to alu.oper
alu_a  output  `const_alu_inout_msb_pos+1  to alu.a_in
alu_b  output  `const_alu_inout_msb_pos+1  to alu.b_in
alu_flags  output  `const_proc_flags_msb_pos+1  to alu.proc_flags_in
alu_out  input  `const_alu_inout_msb_pos+1  from alu.out
alu_flags_res  input  `const_proc_flags_msb_pos+1  from alu.proc_flags_out

Behaviour:
- Reset (asynchronous, active-high): state IDLE; busy, done, err, result_wide, flags_out, chunk index and all internal registers go to 0. Reset mid-RUN aborts the operation: no done, no partial result is retained.
- States and transitions:
  - IDLE: if start=1, latch oper_in, a_wide, b_wide and flags_in. A supported oper goes to RUN with idx=0, carry=flags_in[C], z_acc=1. An unsupported oper goes to DONE with err=1.
  - RUN: on each posedge, capture alu_out into chunk idx of a shadow result, set carry=alu_flags_res[C] and z_acc &= alu_flags_res[Z]. When idx=NUM_CHUNKS-1, go to DONE; otherwise idx+1.
  - DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is accepted exactly as in IDLE.
- Output timing:
  - busy is high only in RUN; start while busy=1 is ignored.
  - Latency: start sampled at edge k → done high in cycle k+1+NUM_CHUNKS for supported ops, and in cycle k+1 for err.
- ALU drive (combinational from registered state):
  - alu_a and alu_b carry chunk idx of the latched operands.
  - alu_flags is the latched flags with the C bit replaced by the running carry.
  - Outside RUN, alu_oper = `enum_alu_oper_add` and alu_a, alu_b, alu_flags are 0.
- Oper mapping per chunk:
  - add: chunk 0 uses add, later chunks use adc.
  - adc: all chunks use adc (chunk 0 takes C from flags_in).
  - sub and cmp: chunk 0 uses sub, later chunks use sbc.
  - sbc: all chunks use sbc.
  - and, orr, xor: the same op on every chunk; carry passes through unchanged.
  - lsl, lsr, asr, rol, ror and any undefined code are unsupported → err.
- Completion:
  - result_wide is loaded from the shadow result for all supported ops except cmp. cmp leaves result_wide unchanged.
  - flags_out is the latched flags_in with C = final carry and Z = z_acc.
  - On err, result_wide is unchanged and flags_out = latched flags_in.
  - err is cleared at the next accepted start.
- Carry convention matches `alu`: C=1 after sub means no borrow.
- NUM_CHUNKS=1 degenerates to a single ALU op with 2-cycle latency.

Test Plan:
1. NUM_CHUNKS=2; add 0x12FF+0x0001, C_in=0 → alu sees add then adc. Result 0x1300, C=0, Z=0. done exactly 3 cycles after the start edge, and busy high for 2 cycles.
2. add 0xFFFF+0x0001 → result 0x0000, C=1, Z=1. Then adc 0x0000+0x0000 with C_in=1 → 0x0001, Z=0.
3. sub 0x1000-0x0001 → 0x0FFF, C=1. Then sub 0x0000-0x0001 → 0xFFFF, C=0. Then sbc 0x0005-0x0003 with C_in=0 → 0x0001.
4. With prior result 0xABCD, cmp 0x1234 vs 0x1234 → Z=1, C=1, result_wide stays 0xABCD. cmp 0x1200 vs 0x1234 → Z=0, C=0.
5. and 0xF0F0&0x0F0F with C_in=1 → 0x0000, Z=1, C=1. Then lsl request → done and err=1 one cycle after start, result unchanged, flags_out=flags_in.
6. Cases:
   - start pulsed while busy → ignored.
   - start held through DONE → back-to-back op accepted.
   - reset asserted mid-RUN → busy, done and result 0 immediately, with no done pulse.
